// File: rtl/grid_keypad_scanner.sv
// grid_keypad_scanner: 3x3 active-low keypad scanner with scan-level debounce.
// Reports one {row,col} strobe per debounced press; key_held tracks the press until debounced release.
module grid_keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 10
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [2:0] row_in,
   output logic [2:0] col_drive,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic {IDLE, HELD} state_t;
   typedef enum logic [1:0] {NONE, SINGLE, MULTI} cls_t;

   logic [2:0]      sync1, sync2;
   logic [DW-1:0]   div;
   logic [1:0]      col;
   logic [1:0][2:0] hit;
   cls_t            prev_cls, cls;
   logic [3:0]      prev_code, code, code_n;
   logic [CW-1:0]   cnt, cnt_n;
   state_t          state, state_n;
   logic            valid_n, sample, scan_done, stable;
   logic [8:0]      hits;
   logic [3:0]      nhits;

   assign sample    = div == DW'(SCAN_DIV - 1);
   assign scan_done = sample && col == 2'd2;
   assign col_drive = ~(3'b001 << col);
   assign key_held  = state == HELD;
   assign hits      = {~sync2, hit[1], hit[0]};

   // Bit c*3+r of hits is the hit for row r, column c; column 2 comes straight from the synchronizer.
   always_comb begin
      nhits = '0;
      code  = '0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++)
            if (hits[c*3+r]) begin
               nhits = nhits + 4'd1;
               code  = {2'(r), 2'(c)};
            end
      cls    = nhits == 4'd0 ? NONE : nhits == 4'd1 ? SINGLE : MULTI;
      code   = cls == SINGLE ? code : 4'h0;
      cnt_n  = (cls == prev_cls && code == prev_code) ?
               (cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + CW'(1)) : CW'(1);
      stable = scan_done && cnt_n == CW'(DEBOUNCE_SCANS);
   end

   always_comb begin
      state_n = state;
      valid_n = 1'b0;
      code_n  = key_code;
      if (state == IDLE && stable && cls == SINGLE) begin
         state_n = HELD;
         valid_n = 1'b1;
         code_n  = code;
      end
      if (state == HELD && stable && cls == NONE)
         state_n = IDLE;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1     <= 3'b111;
         sync2     <= 3'b111;
         div       <= '0;
         col       <= 2'd0;
         hit       <= '0;
         prev_cls  <= NONE;
         prev_code <= 4'h0;
         cnt       <= '0;
         state     <= IDLE;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         sync1     <= row_in;
         sync2     <= sync1;
         div       <= sample ? '0 : div + DW'(1);
         key_valid <= valid_n;
         key_code  <= code_n;
         state     <= state_n;
         if (sample) begin
            col <= col == 2'd2 ? 2'd0 : col + 2'd1;
            if (col != 2'd2)
               hit[col[0]] <= ~sync2;
         end
         if (scan_done) begin
            prev_cls  <= cls;
            prev_code <= code;
            cnt       <= cnt_n;
         end
      end
   end
endmodule

// File: tb/tb_grid_keypad_scanner.sv
// tb_grid_keypad_scanner: keypad emulation plus a cycle-count reference model of the scanner.
module tb_grid_keypad_scanner;
   logic       clk, reset;
   logic [8:0] keys;
   logic [2:0] row_in, col_drive;
   logic [3:0] key_code;
   logic       key_valid, key_held;
   int         tests, fails, pulses;

   grid_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .CLOCK_50(clk), .reset(reset), .row_in(row_in), .col_drive(col_drive),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held));

   always #5 clk = ~clk;

   // keys bit r*3+c closes row r onto column c
   assign row_in[0] = ~|({keys[2], keys[1], keys[0]} & ~col_drive);
   assign row_in[1] = ~|({keys[5], keys[4], keys[3]} & ~col_drive);
   assign row_in[2] = ~|({keys[8], keys[7], keys[6]} & ~col_drive);

   // Reference: edges since reset decide the column and sample points; key index -1 = none, 9 = several.
   int         m_n, m_sig, m_stab;
   logic [2:0] m_p1, m_p2, m_h0, m_h1;
   logic       m_held, m_valid;
   logic [3:0] m_code;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_n <= 0; m_sig <= -1; m_stab <= 0;
         m_p1 <= '0; m_p2 <= '0; m_h0 <= '0; m_h1 <= '0;
         m_held <= 0; m_valid <= 0; m_code <= '0;
      end else begin
         automatic int c, sig, st;
         automatic logic [2:0] cur;
         automatic logic [8:0] all;
         c   = (m_n / 4) % 3;
         cur = {keys[6+c], keys[3+c], keys[c]};
         all = {m_p2, m_h1, m_h0};
         sig = -1;
         m_p1 <= cur;
         m_p2 <= m_p1;
         m_valid <= 0;
         m_n <= m_n + 1;
         if (m_n % 4 == 3 && c == 0) m_h0 <= m_p2;
         if (m_n % 4 == 3 && c == 1) m_h1 <= m_p2;
         if (m_n % 4 == 3 && c == 2) begin
            for (int i = 0; i < 9; i++)
               if (all[i]) sig = (i % 3) * 3 + i / 3;
            if ($countones(all) > 1) sig = 9;
            st = (sig == m_sig) ? (m_stab < 3 ? m_stab + 1 : 3) : 1;
            m_sig <= sig;
            m_stab <= st;
            if (st == 3 && !m_held && sig >= 0 && sig < 9) begin
               m_held <= 1; m_valid <= 1; m_code <= 4'((sig / 3) * 4 + sig % 3);
            end
            if (st == 3 && m_held && sig == -1) m_held <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int cyc);
      logic [2:0] exp_col;
      repeat (cyc) begin
         @(negedge clk);
         exp_col = ~(3'b001 << ((m_n / 4) % 3));
         chk("col_drive", 32'(col_drive), 32'(exp_col));
         chk("key_valid", 32'(key_valid), 32'(m_valid));
         chk("key_held", 32'(key_held), 32'(m_held));
         chk("key_code", 32'(key_code), 32'(m_code));
         if (key_valid) pulses++;
      end
   endtask

   task automatic wait_valid(input int bound, output int cyc);
      cyc = 0;
      do begin
         run(1);
         cyc++;
      end while (!key_valid && cyc < bound);
      chk("strobe_seen", 32'(key_valid), 1);
   endtask

   initial begin
      int cyc, k;
      logic [3:0] want;
      tests = 0; fails = 0; pulses = 0;
      clk = 0; reset = 0; keys = '0;
      #1 reset = 1;
      repeat (2) @(negedge clk);
      chk("rst_col", 32'(col_drive), 32'h6);
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_held", 32'(key_held), 0);
      chk("rst_code", 32'(key_code), 0);
      reset = 0;
      run(360);
      chk("idle_pulses", pulses, 0);

      keys[5] = 1;
      pulses = 0;
      run(51);
      chk("r1c2_pulses", pulses, 1);
      chk("r1c2_code", 32'(key_code), 32'h6);
      chk("r1c2_held", 32'(key_held), 1);
      run(240);
      chk("r1c2_norepeat", pulses, 1);

      keys = '0;
      cyc = 0;
      do begin
         run(1);
         cyc++;
      end while (key_held && cyc < 80);
      chk("release_fall", 32'(key_held), 0);
      chk("release_window", 32'(cyc >= 24 && cyc <= 51), 1);
      chk("code_kept", 32'(key_code), 32'h6);
      keys[8] = 1;
      wait_valid(60, cyc);
      chk("r2c2_code", 32'(key_code), 32'hA);

      keys = '0;
      run(60);
      k = $urandom_range(0, 8);
      want = 4'((k / 3) * 4 + k % 3);
      repeat (12) begin
         keys[k] = ~keys[k];
         run(5);
      end
      keys[k] = 1;
      run(60);
      chk("bounce_held", 32'(key_held), 1);
      chk("bounce_code", 32'(key_code), 32'(want));

      keys = '0;
      run(60);
      keys[0] = 1;
      keys[7] = 1;
      pulses = 0;
      run(120);
      chk("multi_pulses", pulses, 0);
      chk("multi_held", 32'(key_held), 0);
      keys[7] = 0;
      wait_valid(60, cyc);
      chk("multi_then_00", 32'(key_code), 32'h0);

      repeat (4) begin
         keys = '0;
         run(60);
         chk("rand_released", 32'(key_held), 0);
         k = $urandom_range(0, 8);
         want = 4'((k / 3) * 4 + k % 3);
         keys[k] = 1;
         wait_valid(60, cyc);
         chk("rand_code", 32'(key_code), 32'(want));
      end

      keys = '0;
      run(60);
      keys[4] = 1;
      run(24);
      reset = 1;
      #1;
      chk("midrst_col", 32'(col_drive), 32'h6);
      chk("midrst_valid", 32'(key_valid), 0);
      chk("midrst_held", 32'(key_held), 0);
      chk("midrst_code", 32'(key_code), 0);
      run(2);
      reset = 0;
      wait_valid(60, cyc);
      chk("post_rst_latency", cyc, 36);
      chk("post_rst_code", 32'(key_code), 32'h5);
      run(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
